mem_stage: RTL and testbench



---
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake/bus bundle around the MEM stage: EXE->MEM, MEM->WB, MEM->ID bypass and SRAM read return.
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 108
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif

interface mem_stage_if;
  logic                        ws_allowin;
  logic                        ms_allowin;
  logic                        es_to_ms_valid;
  logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [31:0]                 data_sram_rdata;
  logic                        ms_to_ws_valid;
  logic [`MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [37:0]                 stuck_ms_to_ds_bus;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, stuck_ms_to_ds_bus
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, stuck_ms_to_ds_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM pipeline stage: EXE->MEM register, SRAM read capture, load alignment, MEM->WB and MEM->ID buses.
// Optional macro MS_FORWARD_EN: when defined, ID may bypass dest/final_result from MEM instead of stalling.
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 108
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif

module mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.slave pipe
);
  typedef enum logic {HELD = 1'b0, FRESH = 1'b1} rd_state_t;

  rd_state_t                   rd_state_reg, rd_state_next;
  logic                        ms_valid_reg;
  logic [`ES_TO_MS_BUS_WD-1:0] es_bus_reg;
  logic [DATA_W-1:0]           rdata_hold_reg;

  logic              ms_ready_go;
  logic              ms_allowin;
  logic              es_accept;
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] final_result;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [7:0]        mem_byte [4];
  logic [15:0]       mem_half [2];

  logic [31:0] rt_value;
  logic [1:0]  load_addr;
  logic [2:0]  load_inst;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;

  assign {rt_value, load_addr, load_inst, res_from_mem, gr_we, dest, result, pc} = es_bus_reg;

  assign ms_ready_go         = 1'b1;
  assign ms_allowin          = !ms_valid_reg || (ms_ready_go && pipe.ws_allowin);
  assign es_accept           = pipe.es_to_ms_valid && ms_allowin;
  assign pipe.ms_allowin     = ms_allowin;
  assign pipe.ms_to_ws_valid = ms_valid_reg && ms_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_reg   <= 1'b0;
      es_bus_reg     <= '0;
      rd_state_reg   <= HELD;
      rdata_hold_reg <= '0;
    end else begin
      if (ms_allowin) ms_valid_reg <= pipe.es_to_ms_valid;
      if (es_accept)  es_bus_reg   <= pipe.es_to_ms_bus;
      rd_state_reg <= rd_state_next;
      if (rd_state_reg == FRESH) rdata_hold_reg <= pipe.data_sram_rdata;
    end
  end

  // SRAM return is only on the bus the cycle after accept; later stall cycles use the captured copy.
  always_comb begin
    rd_state_next = HELD;
    mem_word      = rdata_hold_reg;
    if (es_accept)              rd_state_next = FRESH;
    if (rd_state_reg == FRESH)  mem_word      = pipe.data_sram_rdata;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign mem_byte[gi] = mem_word[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign mem_half[gi] = mem_word[16*gi +: 16];
    end
  endgenerate

  always_comb begin
    sel_byte   = mem_byte[load_addr];
    sel_half   = mem_half[load_addr[1]];
    load_value = mem_word;
    case (load_inst)
      3'b001: load_value = {{24{sel_byte[7]}}, sel_byte};
      3'b010: load_value = {24'b0, sel_byte};
      3'b011: load_value = {{16{sel_half[15]}}, sel_half};
      3'b100: load_value = {16'b0, sel_half};
      3'b101: begin
        case (load_addr)
          2'd0:    load_value = {mem_word[7:0],  rt_value[23:0]};
          2'd1:    load_value = {mem_word[15:0], rt_value[15:0]};
          2'd2:    load_value = {mem_word[23:0], rt_value[7:0]};
          default: load_value = mem_word;
        endcase
      end
      3'b110: begin
        case (load_addr)
          2'd0:    load_value = mem_word;
          2'd1:    load_value = {rt_value[31:24], mem_word[31:8]};
          2'd2:    load_value = {rt_value[31:16], mem_word[31:16]};
          default: load_value = {rt_value[31:8],  mem_word[31:24]};
        endcase
      end
      default: load_value = mem_word;
    endcase
  end

  assign final_result      = res_from_mem ? load_value : result;
  assign pipe.ms_to_ws_bus = {gr_we, dest, final_result, pc};

  // pending stays 0 with bypass enabled: a load in MEM has already resolved its data.
  always_comb begin
    pipe.stuck_ms_to_ds_bus = '0;
    if (ms_valid_reg && gr_we) begin
`ifdef MS_FORWARD_EN
      pipe.stuck_ms_to_ds_bus = {1'b0, dest, final_result};
`else
      pipe.stuck_ms_to_ds_bus = {1'b1, dest, 32'b0};
`endif
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, load alignment, stall hold, back-to-back, bypass bus.
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 108
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif

module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  mem_stage_if pipe_if ();

  mem_stage #(.DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .pipe   (pipe_if)
  );

  always #5 clk = ~clk;

`ifdef MS_FORWARD_EN
  localparam logic [37:0] FWD_EXP = {1'b0, 5'd5, 32'h42};
`else
  localparam logic [37:0] FWD_EXP = {1'b1, 5'd5, 32'h0};
`endif

  typedef struct packed {
    logic [2:0]  inst;
    logic [1:0]  a;
    logic [31:0] m;
    logic [31:0] r;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [`ES_TO_MS_BUS_WD-1:0] make_bus(
    input logic [31:0] rt, input logic [1:0] a, input logic [2:0] inst, input logic rfm,
    input logic we, input logic [4:0] dest, input logic [31:0] result, input logic [31:0] pc);
    return {rt, a, inst, rfm, we, dest, result, pc};
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    pipe_if.es_to_ms_valid  = 1'b1;
    pipe_if.es_to_ms_bus    = make_bus(32'hFFFF, 2'd1, 3'b001, 1'b1, 1'b1, 5'd7, 32'h55, 32'h80);
    pipe_if.data_sram_rdata = 32'hA5A5A5A5;
    pipe_if.ws_allowin      = 1'b1;
    #2;
    checks++; if (pipe_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pipe_if.ms_to_ws_valid); end
    checks++; if (pipe_if.ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", pipe_if.ms_allowin); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pipe_if.ms_to_ws_bus !== 70'b0) begin errors++; $display("FAIL reset_ws_bus got=%h exp=0", pipe_if.ms_to_ws_bus); end
    checks++; if (pipe_if.stuck_ms_to_ds_bus !== 38'b0) begin errors++; $display("FAIL reset_ds_bus got=%h exp=0", pipe_if.stuck_ms_to_ds_bus); end
    checks++; if (pipe_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_clk got=%b exp=0", pipe_if.ms_to_ws_valid); end
    @(negedge clk);
    resetn = 1'b1;
    pipe_if.es_to_ms_bus = make_bus(32'h0, 2'd0, 3'b000, 1'b0, 1'b1, 5'd3, 32'h77, 32'h40);
    #1;
    checks++; if (pipe_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL release_early_valid got=%b exp=0", pipe_if.ms_to_ws_valid); end
    @(negedge clk);
    pipe_if.es_to_ms_valid = 1'b0;
    #1;
    checks++; if (pipe_if.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL release_first_valid got=%b exp=1", pipe_if.ms_to_ws_valid); end
    checks++; if (pipe_if.ms_to_ws_bus !== {1'b1, 5'd3, 32'h77, 32'h40}) begin errors++; $display("FAIL release_first_bus got=%h exp=%h", pipe_if.ms_to_ws_bus, {1'b1, 5'd3, 32'h77, 32'h40}); end
    @(negedge clk);
    #1;
    checks++; if (pipe_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL release_drain got=%b exp=0", pipe_if.ms_to_ws_valid); end
    $display("test_reset done");
  endtask

  task automatic test_load_align;
    vec_t vecs [13] = '{
      '{3'b001, 2'd2, 32'h12F45678, 32'h0,        32'hFFFFFFF4},
      '{3'b010, 2'd2, 32'h12F45678, 32'h0,        32'h000000F4},
      '{3'b100, 2'd2, 32'h12F45678, 32'h0,        32'h000012F4},
      '{3'b011, 2'd1, 32'hABCD8001, 32'h0,        32'hFFFF8001},
      '{3'b011, 2'd2, 32'hABCD8001, 32'h0,        32'hFFFFABCD},
      '{3'b101, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'hCCDD3344},
      '{3'b110, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h11AABBCC},
      '{3'b101, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'hDD223344},
      '{3'b110, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'h112233AA},
      '{3'b110, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'h1122AABB},
      '{3'b001, 2'd3, 32'h80000000, 32'h0,        32'hFFFFFF80},
      '{3'b111, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'hAABBCCDD},
      '{3'b000, 2'd2, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D}
    };
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      pipe_if.ws_allowin     = 1'b1;
      pipe_if.es_to_ms_valid = 1'b1;
      pipe_if.es_to_ms_bus   = make_bus(vecs[i].r, vecs[i].a, vecs[i].inst, 1'b1, 1'b1,
                                        5'(i), 32'h0BAD0000, 32'h1000 + 32'(4 * i));
      @(negedge clk);
      pipe_if.es_to_ms_valid  = 1'b0;
      pipe_if.data_sram_rdata = vecs[i].m;
      #1;
      checks++;
      if (pipe_if.ms_to_ws_valid !== 1'b1 || pipe_if.ms_to_ws_bus[63:32] !== vecs[i].exp
          || pipe_if.ms_to_ws_bus[31:0] !== 32'h1000 + 32'(4 * i)) begin
        errors++;
        $display("FAIL load_align[%0d] inst=%b a=%0d got valid=%b res=%h pc=%h exp res=%h pc=%h", i,
                 vecs[i].inst, vecs[i].a, pipe_if.ms_to_ws_valid, pipe_if.ms_to_ws_bus[63:32],
                 pipe_if.ms_to_ws_bus[31:0], vecs[i].exp, 32'h1000 + 32'(4 * i));
      end
      $display("load inst=%b a=%0d m=%h r=%h -> %h", vecs[i].inst, vecs[i].a, vecs[i].m, vecs[i].r,
               pipe_if.ms_to_ws_bus[63:32]);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_hold;
    @(negedge clk);
    pipe_if.ws_allowin     = 1'b0;
    pipe_if.es_to_ms_valid = 1'b1;
    pipe_if.es_to_ms_bus   = make_bus(32'h0, 2'd0, 3'b000, 1'b1, 1'b1, 5'd9, 32'h0, 32'h100);
    @(negedge clk);
    pipe_if.data_sram_rdata = 32'h01234567;
    pipe_if.es_to_ms_bus    = make_bus(32'h0, 2'd0, 3'b000, 1'b0, 1'b1, 5'd10, 32'h999, 32'h104);
    #1;
    checks++; if (pipe_if.ms_to_ws_bus[63:32] !== 32'h01234567) begin errors++; $display("FAIL stall_fresh got=%h exp=01234567", pipe_if.ms_to_ws_bus[63:32]); end
    checks++; if (pipe_if.ms_allowin !== 1'b0) begin errors++; $display("FAIL stall_allowin0 got=%b exp=0", pipe_if.ms_allowin); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      pipe_if.data_sram_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (pipe_if.ms_to_ws_bus[63:32] !== 32'h01234567 || pipe_if.ms_allowin !== 1'b0
          || pipe_if.ms_to_ws_valid !== 1'b1 || pipe_if.ms_to_ws_bus[31:0] !== 32'h100) begin
        errors++;
        $display("FAIL stall_held[%0d] got res=%h allowin=%b valid=%b pc=%h exp res=01234567 allowin=0 valid=1 pc=100",
                 c, pipe_if.ms_to_ws_bus[63:32], pipe_if.ms_allowin, pipe_if.ms_to_ws_valid, pipe_if.ms_to_ws_bus[31:0]);
      end
    end
    @(negedge clk);
    pipe_if.ws_allowin     = 1'b1;
    pipe_if.es_to_ms_valid = 1'b0;
    #1;
    checks++; if (pipe_if.ms_to_ws_bus[63:32] !== 32'h01234567 || pipe_if.ms_allowin !== 1'b1) begin errors++; $display("FAIL stall_release got res=%h allowin=%b exp res=01234567 allowin=1", pipe_if.ms_to_ws_bus[63:32], pipe_if.ms_allowin); end
    @(negedge clk);
    #1;
    checks++; if (pipe_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", pipe_if.ms_to_ws_valid); end
    $display("test_stall_hold done");
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_res [3] = '{32'h11111111, 32'h22222222, 32'h33};
    logic [31:0] rdata   [3] = '{32'h11111111, 32'h22222222, 32'hFFFFFFFF};
    @(negedge clk);
    pipe_if.ws_allowin     = 1'b1;
    pipe_if.es_to_ms_valid = 1'b1;
    pipe_if.es_to_ms_bus   = make_bus(32'h0, 2'd0, 3'b000, 1'b1, 1'b1, 5'd2, 32'h0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pipe_if.data_sram_rdata = rdata[i];
      pipe_if.es_to_ms_valid  = (i < 2);
      if (i == 0) pipe_if.es_to_ms_bus = make_bus(32'h0, 2'd0, 3'b000, 1'b1, 1'b1, 5'd3, 32'h0, 32'h204);
      if (i == 1) pipe_if.es_to_ms_bus = make_bus(32'h0, 2'd0, 3'b000, 1'b0, 1'b1, 5'd4, 32'h33, 32'h208);
      #1;
      checks++;
      if (pipe_if.ms_to_ws_valid !== 1'b1 || pipe_if.ms_to_ws_bus !== {1'b1, 5'(2 + i), exp_res[i], 32'h200 + 32'(4 * i)}) begin
        errors++;
        $display("FAIL b2b[%0d] got valid=%b bus=%h exp valid=1 bus=%h", i, pipe_if.ms_to_ws_valid,
                 pipe_if.ms_to_ws_bus, {1'b1, 5'(2 + i), exp_res[i], 32'h200 + 32'(4 * i)});
      end
      $display("b2b pc=%h res=%h", pipe_if.ms_to_ws_bus[31:0], pipe_if.ms_to_ws_bus[63:32]);
    end
    @(negedge clk);
    #1;
    checks++; if (pipe_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", pipe_if.ms_to_ws_valid); end
  endtask

  task automatic test_forward;
    @(negedge clk);
    pipe_if.ws_allowin     = 1'b0;
    pipe_if.es_to_ms_valid = 1'b1;
    pipe_if.es_to_ms_bus   = make_bus(32'h0, 2'd0, 3'b000, 1'b0, 1'b1, 5'd5, 32'h42, 32'h300);
    #1;
    checks++; if (pipe_if.stuck_ms_to_ds_bus !== 38'b0) begin errors++; $display("FAIL fwd_idle got=%h exp=0", pipe_if.stuck_ms_to_ds_bus); end
    @(negedge clk);
    pipe_if.es_to_ms_valid = 1'b0;
    #1;
    checks++; if (pipe_if.stuck_ms_to_ds_bus !== FWD_EXP) begin errors++; $display("FAIL fwd_bus got=%h exp=%h", pipe_if.stuck_ms_to_ds_bus, FWD_EXP); end
    @(negedge clk);
    pipe_if.ws_allowin     = 1'b1;
    pipe_if.es_to_ms_valid = 1'b1;
    pipe_if.es_to_ms_bus   = make_bus(32'h0, 2'd0, 3'b000, 1'b0, 1'b0, 5'd6, 32'h43, 32'h304);
    @(negedge clk);
    pipe_if.es_to_ms_valid = 1'b0;
    #1;
    checks++; if (pipe_if.stuck_ms_to_ds_bus !== 38'b0) begin errors++; $display("FAIL fwd_no_we got=%h exp=0", pipe_if.stuck_ms_to_ds_bus); end
    $display("forward bus=%h", pipe_if.stuck_ms_to_ds_bus);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    pipe_if.ws_allowin     = 1'b0;
    pipe_if.es_to_ms_valid = 1'b1;
    pipe_if.es_to_ms_bus   = make_bus(32'h0, 2'd0, 3'b000, 1'b1, 1'b1, 5'd8, 32'h0, 32'h400);
    @(negedge clk);
    pipe_if.es_to_ms_valid  = 1'b0;
    pipe_if.data_sram_rdata = 32'h55AA55AA;
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (pipe_if.ms_to_ws_valid !== 1'b0 || pipe_if.ms_allowin !== 1'b1 || pipe_if.ms_to_ws_bus !== 70'b0
        || pipe_if.stuck_ms_to_ds_bus !== 38'b0) begin
      errors++;
      $display("FAIL reset_mid_stall got valid=%b allowin=%b bus=%h ds=%h exp 0/1/0/0", pipe_if.ms_to_ws_valid,
               pipe_if.ms_allowin, pipe_if.ms_to_ws_bus, pipe_if.stuck_ms_to_ds_bus);
    end
    @(negedge clk);
    resetn = 1'b1;
    pipe_if.ws_allowin = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (pipe_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_stall_after got=%b exp=0", pipe_if.ms_to_ws_valid); end
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_align();
    test_stall_hold();
    test_back_to_back();
    test_forward();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
